// File: rtl/prio_demux_if.sv
// prio_demux_if: serial word input and wide framed output of the
// 1-to-32 lane distributor, bundled with master (source/sink side)
// and slave (distributor side) modports.
interface prio_demux_if #(
  parameter int WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic [4:0]            in_sel;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [32*WIDTH-1:0]   out_data;
  logic [31:0]           out_mask;

  modport master (
    output in_valid, in_data, in_sel, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_mask
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_last, out_ready,
    output in_ready, out_valid, out_data, out_mask
  );
endinterface

// File: rtl/prio_demux.sv
// prio_demux: registered 1-to-32 lane distributor. Serial lane-tagged
// words are assembled into an accumulation frame (A) and handed over as
// one wide, double-buffered frame (B) with a valid/ready handshake.
// Optional feature: define PRIO_DEMUX_AUTOSEL_EN to take the lane index
// from an internal counter and auto-close the frame on lane 31.
module prio_demux #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  prio_demux_if.slave bus
);
  localparam int LANES = 32;
  localparam int FW    = LANES * WIDTH;

  typedef enum logic {
    FILL   = 1'b0,
    CLOSED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [FW-1:0]    a_data_q, a_data_d;
  logic [LANES-1:0] a_mask_q, a_mask_d;
  logic [FW-1:0]    b_data_q, b_data_d;
  logic [LANES-1:0] b_mask_q, b_mask_d;

  logic             accept;
  logic             closing;
  logic             drain;
  logic             transfer;
  logic [4:0]       lane;
  logic [FW-1:0]    a_wr_data;
  logic [LANES-1:0] a_wr_mask;

`ifdef PRIO_DEMUX_AUTOSEL_EN
  logic [4:0]       cnt_q, cnt_d;
`endif

  assign accept = bus.in_valid && in_ready_q;
  assign drain  = out_valid_q && bus.out_ready;

  // Pick the destination lane and decide whether this word closes the frame.
  always_comb begin
`ifdef PRIO_DEMUX_AUTOSEL_EN
    lane    = cnt_q;
    closing = accept && (bus.in_last || (cnt_q == 5'd31));
`else
    lane    = bus.in_sel;
    closing = accept && bus.in_last;
`endif
  end

  // Accumulation frame with the current word (if any) merged in.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    a_wr_data = a_data_q;
    a_wr_mask = a_mask_q;
    if (accept) begin
      a_wr_data[lane*WIDTH +: WIDTH] = bus.in_data;
      a_wr_mask[lane]                = 1'b1;
    end
  end

  // Frame hand-over and fill/closed sequencing.
  always_comb begin
    state_d     = state_q;
    a_data_d    = a_wr_data;
    a_mask_d    = a_wr_mask;
    b_data_d    = b_data_q;
    b_mask_d    = b_mask_q;
    out_valid_d = out_valid_q;
    transfer    = ((state_q == FILL) && closing && (!out_valid_q || drain)) ||
                  ((state_q == CLOSED) && drain);
    if (transfer) begin
      b_data_d    = a_wr_data;
      b_mask_d    = a_wr_mask;
      a_data_d    = '0;
      a_mask_d    = '0;
      out_valid_d = 1'b1;
      state_d     = FILL;
    end else begin
      if (closing) state_d = CLOSED;
      if (drain)   out_valid_d = 1'b0;
    end
    in_ready_d = (state_d == FILL);
  end

`ifdef PRIO_DEMUX_AUTOSEL_EN
  // Auto lane counter: advances per accepted word, restarts on every close.
  always_comb begin
    cnt_d = cnt_q;
    if (closing)     cnt_d = 5'd0;
    else if (accept) cnt_d = cnt_q + 5'd1;
  end
`endif

  // State registers, including both frame buffers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the frame buffers are reset too, because unwritten lanes and a discarded frame must read as zero.
      state_q     <= FILL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_data_q    <= '0;
      a_mask_q    <= '0;
      b_data_q    <= '0;
      b_mask_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values together.
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      a_data_q    <= a_data_d;
      a_mask_q    <= a_mask_d;
      b_data_q    <= b_data_d;
      b_mask_q    <= b_mask_d;
    end
  end

`ifdef PRIO_DEMUX_AUTOSEL_EN
  // Auto lane counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 5'd0;
    else     cnt_q <= cnt_d;
  end
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = b_data_q;
  assign bus.out_mask  = b_mask_q;
endmodule

// File: tb/tb_prio_demux.sv
// tb_prio_demux: directed and randomized stimulus for prio_demux, checked
// every cycle against a frame-level reference model.
module tb_prio_demux;
  localparam int W  = 32;
  localparam int FW = 32 * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  prio_demux_if #(.WIDTH(W)) bus ();

  prio_demux #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: frame under construction, whether it is waiting,
  // and the frame on display.
  logic [W-1:0] m_a [32];
  logic [31:0]  m_a_mask;
  logic         m_closed;
  logic [W-1:0] m_b [32];
  logic [31:0]  m_b_mask;
  logic         m_b_valid;
  int           m_cnt;

  task automatic model_reset();
    for (int k = 0; k < 32; k++) begin
      m_a[k] = '0;
      m_b[k] = '0;
    end
    m_a_mask  = '0;
    m_b_mask  = '0;
    m_closed  = 1'b0;
    m_b_valid = 1'b0;
    m_cnt     = 0;
  endtask

  // Apply one clock edge of the frame rules to the model using current inputs.
  task automatic model_step();
    bit accept, drain, closing, move;
    int ln;
    accept = bus.in_valid && !m_closed;
    drain  = m_b_valid && bus.out_ready;
`ifdef PRIO_DEMUX_AUTOSEL_EN
    ln = m_cnt;
`else
    ln = int'(bus.in_sel);
`endif
    closing = 1'b0;
    if (accept) begin
      m_a[ln]      = bus.in_data;
      m_a_mask[ln] = 1'b1;
      closing      = bus.in_last;
`ifdef PRIO_DEMUX_AUTOSEL_EN
      if (ln == 31) closing = 1'b1;
      m_cnt = closing ? 0 : m_cnt + 1;
`endif
    end
    move = (closing && (!m_b_valid || drain)) || (m_closed && drain);
    if (move) begin
      for (int k = 0; k < 32; k++) begin
        m_b[k] = m_a[k];
        m_a[k] = '0;
      end
      m_b_mask  = m_a_mask;
      m_a_mask  = '0;
      m_closed  = 1'b0;
      m_b_valid = 1'b1;
    end else begin
      if (closing) m_closed = 1'b1;
      if (drain)   m_b_valid = 1'b0;
    end
  endtask

  task automatic check_all(string tag);
    logic [FW-1:0] exp_data;
    int bad;
    for (int k = 0; k < 32; k++) exp_data[k*W +: W] = m_b[k];
    checks++;
    assert (bus.in_ready === ~m_closed)
      else begin errors++; $error("FAIL %s in_ready obs=%b exp=%b", tag, bus.in_ready, ~m_closed); end
    checks++;
    assert (bus.out_valid === m_b_valid)
      else begin errors++; $error("FAIL %s out_valid obs=%b exp=%b", tag, bus.out_valid, m_b_valid); end
    checks++;
    assert (bus.out_mask === m_b_mask)
      else begin errors++; $error("FAIL %s out_mask obs=%h exp=%h", tag, bus.out_mask, m_b_mask); end
    checks++;
    assert (bus.out_data === exp_data)
      else begin
        errors++;
        bad = 0;
        for (int k = 31; k >= 0; k--) if (bus.out_data[k*W +: W] !== exp_data[k*W +: W]) bad = k;
        $error("FAIL %s out_data lane %0d obs=%h exp=%h", tag, bad,
               bus.out_data[bad*W +: W], exp_data[bad*W +: W]);
      end
  endtask

  // Directed comparison against a constant taken from the frame rules.
  task automatic fixed(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin errors++; $error("FAIL %s obs=%h exp=%h", tag, obs, exp); end
  endtask

  task automatic drive(bit v, int sel, logic [W-1:0] data, bit last, bit rdy);
    bus.in_valid  = v;
    bus.in_sel    = 5'(sel);
    bus.in_data   = data;
    bus.in_last   = last;
    bus.out_ready = rdy;
  endtask

  task automatic cycle(string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    drive(0, 0, '0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    rst = 1'b0;
  endtask

  initial begin
    drive(0, 0, '0, 0, 0);
    model_reset();
    #2;
    do_reset();

    // Full 32-lane frame.
    for (int k = 0; k < 32; k++) begin
      drive(1, k, W'(k + 100), k == 31, 1);
      cycle("full");
    end
    fixed("full_valid", {31'd0, bus.out_valid}, 32'd1);
    fixed("full_mask", bus.out_mask, 32'hFFFF_FFFF);
    fixed("full_lane0", bus.out_data[0 +: W], 32'd100);
    fixed("full_lane31", bus.out_data[31*W +: W], 32'd131);
    drive(0, 0, '0, 0, 1);
    cycle("full_drain");

`ifndef PRIO_DEMUX_AUTOSEL_EN
    // Sparse frame with a lane overwrite.
    drive(1, 3, 32'hA, 0, 1); cycle("sparse");
    drive(1, 7, 32'hB, 0, 1); cycle("sparse");
    drive(1, 3, 32'hC, 1, 1); cycle("sparse");
    fixed("sparse_mask", bus.out_mask, 32'h0000_0088);
    fixed("sparse_lane3", bus.out_data[3*W +: W], 32'hC);
    fixed("sparse_lane7", bus.out_data[7*W +: W], 32'hB);
    fixed("sparse_lane0", bus.out_data[0 +: W], 32'h0);
    drive(0, 0, '0, 0, 1);
    cycle("sparse_drain");
`endif

    // Backpressure: F1 then F2 with the sink stalled.
    drive(1, 1, 32'h11, 0, 0); cycle("bp_f1");
    drive(1, 2, 32'h12, 1, 0); cycle("bp_f1");
    drive(1, 4, 32'h21, 1, 0); cycle("bp_f2");
    fixed("bp_closed_ready", {31'd0, bus.in_ready}, 32'd0);
    drive(1, 5, 32'h99, 1, 0); cycle("bp_ignored");
    drive(0, 0, '0, 0, 0); cycle("bp_hold");
    drive(0, 0, '0, 0, 1); cycle("bp_pulse");
    fixed("bp_f2_lane4", bus.out_data[4*W +: W], 32'h21);
    fixed("bp_exit_ready", {31'd0, bus.in_ready}, 32'd1);
    drive(0, 0, '0, 0, 0); cycle("bp_hold2");
    drive(0, 0, '0, 0, 1); cycle("bp_drain");

    // Back-to-back single-word frames.
    for (int k = 0; k < 8; k++) begin
      drive(1, k * 3, W'(32'h500 + k), 1, 1);
      cycle("b2b");
      fixed("b2b_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    drive(0, 0, '0, 0, 1); cycle("b2b_drain");

    // Reset while CLOSED with B full.
    drive(1, 6, 32'h61, 1, 0); cycle("rst_f1");
    drive(1, 9, 32'h62, 1, 0); cycle("rst_f2");
    do_reset();
    fixed("rst_mask", bus.out_mask, 32'h0);
    drive(1, 2, 32'h77, 1, 1); cycle("post_rst");
`ifndef PRIO_DEMUX_AUTOSEL_EN
    fixed("post_rst_mask", bus.out_mask, 32'h0000_0004);
`endif
    drive(0, 0, '0, 0, 1); cycle("post_rst_drain");

`ifdef PRIO_DEMUX_AUTOSEL_EN
    // Auto lane select: 40 words with no in_last.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      drive(1, 31 - (k % 32), W'(k), 0, 1);
      cycle("auto");
      if (k == 31) begin
        fixed("auto_mask", bus.out_mask, 32'hFFFF_FFFF);
        fixed("auto_lane31", bus.out_data[31*W +: W], 32'd31);
      end
    end
    drive(1, 0, W'(40), 1, 1); cycle("auto_close");
    fixed("auto2_mask", bus.out_mask, 32'h0000_01FF);
    fixed("auto2_lane7", bus.out_data[7*W +: W], 32'd39);
    drive(0, 0, '0, 0, 1); cycle("auto_drain");
`endif

    // Randomized traffic with one mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 31)), W'($urandom),
            $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
